// File: rtl/dram_write_buffer_pkg.sv
// Shared types and constants for the DRAM store write buffer.
// Entry layout is {adr, data}; both fields are full words.
package dram_write_buffer_pkg;

  localparam int XLEN       = 32;
  localparam int WBUF_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] adr;
    logic [XLEN-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Store-to-load forwarding: full-address match over valid entries,
// youngest match wins.
module wbuf_fwd_match
  import dram_write_buffer_pkg::*;
#(
  parameter  int DEPTH = WBUF_DEPTH,
  localparam int PW    = $clog2(DEPTH)
) (
  input  wbuf_entry_t     ent_i [DEPTH],
  input  logic [DEPTH-1:0] vld_i,
  input  logic [PW-1:0]    head_i,
  input  logic [XLEN-1:0]  adr_i,
  output logic             hit_o,
  output logic [XLEN-1:0]  data_o
);

  logic [PW-1:0] idx;

  // Walk from the head (oldest) towards the tail so the last
  // match found is the youngest one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if (vld_i[idx] && (ent_i[idx].adr == adr_i)) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/dram_write_buffer.sv
// In-order store buffer between CPU and DRAM with load forwarding.
// Pops present the head entry; pushes are visible from the next cycle.
module dram_write_buffer
  import dram_write_buffer_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [XLEN-1:0] st_adr,
  input  logic [XLEN-1:0] st_wdin,
  input  logic [XLEN-1:0] ld_adr,
  input  logic [XLEN-1:0] ld_rd_in,
  output logic [XLEN-1:0] ld_rd_out,
  output logic            ld_hit,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_adr,
  output logic [XLEN-1:0] mem_wdin,
  input  logic            mem_ready,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t      ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic            push;
  logic            pop;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  assign empty    = (cnt_q == '0);
  assign st_ready = (cnt_q != CW'(DEPTH));
  assign mem_we   = !empty;
  assign push     = st_valid && st_ready;
  assign pop      = mem_we && mem_ready;

  assign mem_adr  = empty ? '0 : ent_q[rp_q].adr;
  assign mem_wdin = empty ? '0 : ent_q[rp_q].data;

  // Push and pop never target the same slot: push needs !full,
  // pop needs !empty, and wp==rp only in those two states.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (push) begin
      vld_d[wp_q] = 1'b1;
      wp_d        = wp_q + PW'(1);
    end
    if (pop) begin
      vld_d[rp_q] = 1'b0;
      rp_d        = rp_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // Payload storage is qualified by vld_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ent_q[wp_q].adr  <= st_adr;
      ent_q[wp_q].data <= st_wdin;
    end
  end

  wbuf_fwd_match #(
    .DEPTH (DEPTH)
  ) u_fwd (
    .ent_i  (ent_q),
    .vld_i  (vld_q),
    .head_i (rp_q),
    .adr_i  (ld_adr),
    .hit_o  (fwd_hit),
    .data_o (fwd_data)
  );

  assign ld_hit    = fwd_hit;
  assign ld_rd_out = fwd_hit ? fwd_data : ld_rd_in;

endmodule

// File: tb/tb_dram_write_buffer.sv
// Self-checking bench for dram_write_buffer against a queue model.
// Directed scenarios followed by a randomized run with small address pool.
module tb_dram_write_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] st_adr = '0;
  logic [31:0] st_wdin = '0;
  logic [31:0] ld_adr = '0;
  logic [31:0] ld_rd_in = '0;
  logic        st_ready;
  logic [31:0] ld_rd_out;
  logic        ld_hit;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdin;
  logic        empty;
  logic [99:0] obs;

  int vectors = 0;
  int errors  = 0;

  ent_t mq[$];
  ent_t plog[$];
  ent_t wlog[$];

  dram_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_adr    (st_adr),
    .st_wdin   (st_wdin),
    .ld_adr    (ld_adr),
    .ld_rd_in  (ld_rd_in),
    .ld_rd_out (ld_rd_out),
    .ld_hit    (ld_hit),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdin  (mem_wdin),
    .mem_ready (mem_ready),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  assign obs = {st_ready, mem_we, empty, ld_hit,
                mem_adr, mem_wdin, ld_rd_out};

  function automatic logic [99:0] exp_vec();
    logic        hit;
    logic [31:0] rd, a, d;
    hit = 1'b0;
    rd  = ld_rd_in;
    a   = '0;
    d   = '0;
    foreach (mq[i])
      if (mq[i].adr == ld_adr) begin
        hit = 1'b1;
        rd  = mq[i].data;
      end
    if (mq.size() > 0) begin
      a = mq[0].adr;
      d = mq[0].data;
    end
    return {mq.size() < DEPTH, mq.size() > 0, mq.size() == 0,
            hit, a, d, rd};
  endfunction

  task automatic tick();
    bit   push, pop;
    ent_t e;
    push   = st_valid && (mq.size() < DEPTH) && !rst;
    pop    = (mq.size() > 0) && mem_ready && !rst;
    e.adr  = st_adr;
    e.data = st_wdin;
    if (mem_we && mem_ready && !rst)
      wlog.push_back({mem_adr, mem_wdin});
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        plog.push_back(e);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    st_valid = 1'b0;
    mem_ready = 1'b0;
    tick();
    rst = 1'b0;
    plog.delete();
    wlog.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    st_valid = 1'b1;
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    st_valid = 1'b0;
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({empty, mem_we, st_ready, ld_hit} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1010",
               {empty, mem_we, st_ready, ld_hit});
    end
    vectors++;
    if ({mem_adr, mem_wdin} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem: got %h want 0", {mem_adr, mem_wdin});
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1;
      st_adr   = 32'h100 + 32'(4 * i);
      st_wdin  = 32'hA + 32'(i);
      #1;
      vectors++;
      if (i == 0 && mem_we !== 1'b0) begin
        errors++;
        $display("FAIL hold_latency: mem_we got %b want 0", mem_we);
      end else if (i > 0 &&
                   {mem_we, mem_adr, mem_wdin} !== {1'b1, 32'h100, 32'hA}) begin
        errors++;
        $display("FAIL hold_head: got %h want 1_100_A",
                 {mem_we, mem_adr, mem_wdin});
      end
      tick();
    end
    st_valid = 1'b0;
    #1;
    vectors++;
    if ({mem_we, empty, st_ready, mem_adr, mem_wdin} !==
        {3'b101, 32'h100, 32'hA}) begin
      errors++;
      $display("FAIL hold_three: got %h want 5_100_A",
               {mem_we, empty, st_ready, mem_adr, mem_wdin});
    end
    st_valid = 1'b1;
    st_adr   = 32'h10C;
    st_wdin  = 32'hD;
    tick();
    st_valid = 1'b0;
    #1;
    vectors++;
    if (st_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_count3: st_ready got %b want 0", st_ready);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      st_valid = 1'b1;
      st_adr   = 32'h300 + 32'(4 * i);
      st_wdin  = $urandom;
      tick();
    end
    st_adr    = 32'h310;
    st_wdin   = 32'h5555;
    mem_ready = 1'b1;
    #1;
    vectors++;
    if ({st_ready, mem_we, mem_adr} !== {2'b01, 32'h300}) begin
      errors++;
      $display("FAIL full_block: got %h want 1_300",
               {st_ready, mem_we, mem_adr});
    end
    tick();
    vectors++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_reopen: st_ready got %b want 1", st_ready);
    end
    tick();
    st_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      vectors++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL full_drain: got %h want %h", obs, exp_vec());
      end
      tick();
    end
    vectors++;
    if (wlog.size() != 5 || plog.size() != 5 || wlog != plog) begin
      errors++;
      $display("FAIL full_order: got %0d writes want 5 in push order",
               wlog.size());
    end
  endtask

  task automatic test_forward();
    do_reset();
    ld_adr   = 32'h200;
    ld_rd_in = 32'hDEAD;
    st_valid = 1'b1;
    st_adr   = 32'h200;
    st_wdin  = 32'h1;
    #1;
    vectors++;
    if ({ld_hit, ld_rd_out} !== {1'b0, 32'hDEAD}) begin
      errors++;
      $display("FAIL fwd_same_cycle: got %h want 0_DEAD", {ld_hit, ld_rd_out});
    end
    tick();
    st_wdin = 32'h2;
    #1;
    vectors++;
    if ({ld_hit, ld_rd_out} !== {1'b1, 32'h1}) begin
      errors++;
      $display("FAIL fwd_one: got %h want 1_1", {ld_hit, ld_rd_out});
    end
    tick();
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if ({ld_hit, ld_rd_out} !== {1'b1, 32'h2}) begin
        errors++;
        $display("FAIL fwd_youngest: got %h want 1_2", {ld_hit, ld_rd_out});
      end
      tick();
    end
    #1;
    vectors++;
    if ({ld_hit, ld_rd_out, empty} !== {1'b0, 32'hDEAD, 1'b1}) begin
      errors++;
      $display("FAIL fwd_drained: got %h want 0_DEAD_1",
               {ld_hit, ld_rd_out, empty});
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      st_valid  = 1'b1;
      st_adr    = 32'h400 + 32'(4 * i);
      st_wdin   = $urandom;
      mem_ready = (i >= 2);
      #1;
      vectors++;
      if (obs !== exp_vec() || (i >= 2 && st_ready !== 1'b1)) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %h want %h", i, obs, exp_vec());
      end
      tick();
    end
    st_valid  = 1'b0;
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (wlog.size() != 5 || wlog != plog[0:4] ||
        {mem_adr, st_ready} !== {32'h414, 1'b1}) begin
      errors++;
      $display("FAIL b2b_order: got %0d writes head %h want 5 head 414",
               wlog.size(), mem_adr);
    end
    mem_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (empty !== 1'b1 || wlog.size() != 7) begin
      errors++;
      $display("FAIL b2b_count2: empty %b writes %0d want 1 and 7",
               empty, wlog.size());
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1;
      st_adr   = 32'h600 + 32'(4 * i);
      st_wdin  = $urandom;
      tick();
    end
    rst       = 1'b1;
    mem_ready = 1'b1;
    tick();
    rst      = 1'b0;
    st_valid = 1'b0;
    #1;
    vectors++;
    if ({empty, mem_we, st_ready} !== 3'b101) begin
      errors++;
      $display("FAIL midrst_flags: got %b want 101",
               {empty, mem_we, st_ready});
    end
    wlog.delete();
    for (int c = 0; c < 4; c++) tick();
    vectors++;
    if (wlog.size() != 0) begin
      errors++;
      $display("FAIL midrst_writes: got %0d want 0", wlog.size());
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    cyc = 0;
    while (!(plog.size() == 10 && mq.size() == 0) && cyc < 100) begin
      st_valid  = (plog.size() < 10);
      st_adr    = 32'h500 + 32'(4 * plog.size());
      st_wdin   = 32'hC0DE0000 + 32'(plog.size());
      mem_ready = cyc[0];
      #1;
      vectors++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_cycle%0d: got %h want %h", cyc, obs, exp_vec());
      end
      tick();
      cyc++;
    end
    st_valid  = 1'b0;
    mem_ready = 1'b0;
    vectors++;
    if (cyc >= 100 || wlog.size() != 10 || wlog != plog) begin
      errors++;
      $display("FAIL wrap_order: got %0d writes in %0d cycles want 10",
               wlog.size(), cyc);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 49) == 0);
      st_valid  = $urandom_range(0, 1);
      st_adr    = 32'h10 + 32'(4 * $urandom_range(0, 3));
      st_wdin   = $urandom;
      mem_ready = ($urandom_range(0, 2) != 0);
      ld_adr    = 32'h10 + 32'(4 * $urandom_range(0, 4));
      ld_rd_in  = $urandom;
      #1;
      vectors++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL rand_cycle%0d: got %h want %h", c, obs, exp_vec());
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold();
    test_full();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
